level_outcome_ctrl: RTL
=======================

// Module: level_outcome_ctrl
// PURPOSE
//  Judges the running level. Drives the levelPassed / lose inputs of GameFSM.
//  Watches the scroll visibility flags from Scrolls and the wall-collision flag from the wall/player overlap logic.
//  Runs a per-level countdown and a lives counter.
//  Emits exactly one outcome pulse per level.
// PARAMETERS
//  N_SCROLLS      24           scroll count; flattened 4x6 grid, index row*6+col
//  TICK_DIV       100_000_000  clk cycles per 1 s game tick
//  TIME_LIMIT_S   60           countdown reload value in seconds (<=255)
//  MAX_LIVES      3            lives reload value (1..3)
//  COOLDOWN_S     2            seconds of hit immunity after a wall hit
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous active-high reset
//  level_start    in   1          1-cycle pulse; a new level begins
//  scroll_visible in   N_SCROLLS  1 = scroll not yet collected
//  wall_hit       in   1          level: player overlaps a wall this cycle
//  pause          in   1          freeze timer and ignore hits while high
//  levelPassed    out  1          1-cycle pulse; all scrolls collected
//  lose           out  1          1-cycle pulse; time out or lives exhausted
//  time_left      out  8          seconds remaining
//  lives          out  2          lives remaining
//  scrolls_left   out  5          registered popcount of scroll_visible
//  state          out  2          IDLE=0, PLAY=1, COOLDOWN=2, DONE=3
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE, levelPassed=0, lose=0.
//    - time_left=TIME_LIMIT_S, lives=MAX_LIVES, scrolls_left=0, prescaler=0.
//  - scrolls_left: registered popcount of scroll_visible, updated every cycle, 1-cycle latency.
//  - level_start: honoured in any state. Priority is below rst and above every other event.
//    - Action: state->PLAY, time_left reload, prescaler clear.
//    - lives are NOT reloaded; they reload only on rst or after a lose.
//  - Prescaler:
//    - Counts 0..TICK_DIV-1 in PLAY and COOLDOWN while pause=0; frozen while pause=1.
//    - On wrap it raises the internal tick for 1 cycle.
//  - Tick effects:
//    - time_left decrements, saturating at 0.
//    - In COOLDOWN, the cooldown counter decrements.
//  - PLAY:
//    - scrolls_left==0 -> levelPassed pulse, state->DONE.
//    - else time_left==0 -> lose pulse, state->DONE.
//    - else a rising edge of wall_hit (pause=0) -> lives-1.
//      - lives becomes 0 -> lose pulse, state->DONE, lives reload to MAX_LIVES.
//      - otherwise state->COOLDOWN, cooldown counter=COOLDOWN_S.
//  - COOLDOWN:
//    - wall_hit is ignored.
//    - Pass and timeout checks are the same as in PLAY.
//    - Cooldown counter reaches 0 on a tick -> PLAY.
//  - DONE: outputs hold; no pulses; waits for level_start.
//  - Same-cycle events: pass beats timeout beats hit.
//  - levelPassed and lose are never high in the same cycle.
//  - rst mid-level: immediate return to reset values. No pulse is emitted.
//  - Edge detect on wall_hit uses a 1-cycle delayed copy. That register clears on rst and on level_start.
// CONFIGURATION
//  - LEVEL_OUTCOME_BONUS_TIME_EN defined:
//    - Each cycle where scrolls_left decreases (PLAY/COOLDOWN) adds 2 s to time_left, saturating at 255.
//    - If a bonus and a tick land on the same cycle, the net change is +1.
//  - Not defined: no time bonus; time_left changes only on tick and reload.
// STRUCTURE
//  - Shared package game_pkg: state encoding constants (IDLE/PLAY/COOLDOWN/DONE), N_SCROLLS=24, and the grid dims 4x6.
//    GameFSM and Scrolls use the same package.
//  - One sub-module, tick_prescaler (params TICK_DIV; ports clk, rst, en, tick).
//    It is also reusable for on-screen timer blink.
// TESTING  (bench uses TICK_DIV=4, TIME_LIMIT_S=5, MAX_LIVES=3, COOLDOWN_S=2)
//  - rst high 2 cycles, then low -> state=0, time_left=5, lives=3, both pulses 0.
//  - level_start, scroll_visible=24'h1 held -> time_left steps 5..0, one tick every 4 cycles.
//    Expected: lose=1 for exactly 1 cycle at time 0, then state=3.
//  - level_start, then scroll_visible 24'h3 -> 24'h1 -> 24'h0 -> levelPassed 1-cycle pulse 2 cycles after the 0 arrives.
//    Expected: lose stays 0.
//  - wall_hit held high 20 cycles -> lives 3->2 once; state=2 for 8 cycles, then 1.
//    A further held high does not re-trigger until it falls and rises again.
//    Three separated hits -> lose pulse, lives=3.
//  - Last scroll clears in the same cycle time_left hits 0 -> only levelPassed pulses.
//    pause=1 for 12 cycles -> time_left unchanged.
//  - With LEVEL_OUTCOME_BONUS_TIME_EN: time_left=3, 24'h3 -> 24'h1 -> time_left=5.
//    With time_left=254 and a collect -> 255.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and scroll grid geometry.
// Used by level_outcome_ctrl, GameFSM and Scrolls.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        COOLDOWN = 2'd2,
        DONE     = 2'd3
    } game_state_e;

    localparam int GRID_ROWS    = 4;
    localparam int GRID_COLS    = 6;
    localparam int N_SCROLLS    = GRID_ROWS * GRID_COLS;  // flattened index row*6+col
    localparam int SCROLL_CNT_W = $clog2(N_SCROLLS + 1);

endpackage

// File: rtl/level_outcome_ctrl_if.sv
// Level-judge signal bundle: master is the game side driving level events,
// slave is level_outcome_ctrl reporting outcome, timer and lives.
interface level_outcome_ctrl_if;
    import game_pkg::*;

    logic                    level_start;
    logic [N_SCROLLS-1:0]    scroll_visible;
    logic                    wall_hit;
    logic                    pause;
    logic                    levelPassed;
    logic                    lose;
    logic [7:0]              time_left;
    logic [1:0]              lives;
    logic [SCROLL_CNT_W-1:0] scrolls_left;
    logic [1:0]              state;

    modport master (
        output level_start, scroll_visible, wall_hit, pause,
        input  levelPassed, lose, time_left, lives, scrolls_left, state
    );

    modport slave (
        input  level_start, scroll_visible, wall_hit, pause,
        output levelPassed, lose, time_left, lives, scrolls_left, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a 1-cycle tick every TICK_DIV enabled cycles.
// Frozen while en is low; also reused for on-screen timer blink.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] countReg;

    assign tick = en && (countReg == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            countReg <= '0;
        end else if (en) begin
            countReg <= tick ? '0 : countReg + 1'b1;
        end
    end

endmodule

// File: rtl/level_outcome_ctrl.sv
// Level judge: countdown, lives and wall-hit cooldown; one pass/lose pulse per level.
// Optional LEVEL_OUTCOME_BONUS_TIME_EN: +2 s of time for every scroll collected.
module level_outcome_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100_000_000,
    parameter int unsigned TIME_LIMIT_S = 60,
    parameter int unsigned MAX_LIVES    = 3,
    parameter int unsigned COOLDOWN_S   = 2
) (
    input logic                 clk,
    input logic                 rst,
    level_outcome_ctrl_if.slave bus
);
    game_state_e             stateReg, stateNext;
    logic [7:0]              timeLeftReg, timeLeftNext;
    logic [1:0]              livesReg, livesNext;
    logic [7:0]              cooldownReg, cooldownNext;
    logic [SCROLL_CNT_W-1:0] scrollsLeftReg;
    logic                    wallHitDlyReg;
    logic                    levelPassedReg, levelPassedNext;
    logic                    loseReg, loseNext;

    logic                    active;
    logic                    tickEn;
    logic                    tick;
    logic                    hitRise;
    logic [SCROLL_CNT_W-1:0] scrollCount;
    logic [2:0]              rowCount [GRID_ROWS];
    logic [9:0]              timeSum;
    logic [7:0]              timeTicked;

    // Popcount built per grid row, then summed.
    for (genvar gi = 0; gi < GRID_ROWS; gi++) begin : g_row
        assign rowCount[gi] = 3'($countones(bus.scroll_visible[gi*GRID_COLS +: GRID_COLS]));
    end

    always_comb begin
        scrollCount = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            scrollCount = scrollCount + SCROLL_CNT_W'(rowCount[r]);
        end
    end

    assign active  = (stateReg == PLAY) || (stateReg == COOLDOWN);
    assign tickEn  = active && !bus.pause;
    assign hitRise = bus.wall_hit && !wallHitDlyReg && !bus.pause;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst || bus.level_start),
        .en   (tickEn),
        .tick (tick)
    );

    // Next time_left while the level runs; widened so bonus and tick net out before clamping.
    always_comb begin
        timeSum = {2'b00, timeLeftReg};
`ifdef LEVEL_OUTCOME_BONUS_TIME_EN
        if (scrollCount < scrollsLeftReg) begin
            timeSum = timeSum + 10'd2;
        end
`endif
        if (tick && (timeSum != '0)) begin
            timeSum = timeSum - 10'd1;
        end
        timeTicked = (timeSum > 10'd255) ? 8'hFF : timeSum[7:0];
    end

    always_comb begin
        stateNext       = stateReg;
        timeLeftNext    = timeLeftReg;
        livesNext       = livesReg;
        cooldownNext    = cooldownReg;
        levelPassedNext = 1'b0;
        loseNext        = 1'b0;

        if (bus.level_start) begin
            stateNext    = PLAY;
            timeLeftNext = 8'(TIME_LIMIT_S);
            cooldownNext = '0;
        end else if (active) begin
            timeLeftNext = timeTicked;
            if (scrollsLeftReg == '0) begin
                levelPassedNext = 1'b1;
                stateNext       = DONE;
            end else if (timeLeftReg == '0) begin
                loseNext  = 1'b1;
                stateNext = DONE;
                livesNext = 2'(MAX_LIVES);
            end else if ((stateReg == PLAY) && hitRise) begin
                if (livesReg <= 2'd1) begin
                    loseNext  = 1'b1;
                    stateNext = DONE;
                    livesNext = 2'(MAX_LIVES);
                end else begin
                    livesNext    = livesReg - 2'd1;
                    stateNext    = COOLDOWN;
                    cooldownNext = 8'(COOLDOWN_S);
                end
            end else if ((stateReg == COOLDOWN) && tick) begin
                if (cooldownReg <= 8'd1) begin
                    cooldownNext = '0;
                    stateNext    = PLAY;
                end else begin
                    cooldownNext = cooldownReg - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg       <= IDLE;
            timeLeftReg    <= 8'(TIME_LIMIT_S);
            livesReg       <= 2'(MAX_LIVES);
            cooldownReg    <= '0;
            scrollsLeftReg <= '0;
            wallHitDlyReg  <= 1'b0;
            levelPassedReg <= 1'b0;
            loseReg        <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            timeLeftReg    <= timeLeftNext;
            livesReg       <= livesNext;
            cooldownReg    <= cooldownNext;
            scrollsLeftReg <= scrollCount;
            wallHitDlyReg  <= bus.level_start ? 1'b0 : bus.wall_hit;
            levelPassedReg <= levelPassedNext;
            loseReg        <= loseNext;
        end
    end

    assign bus.levelPassed  = levelPassedReg;
    assign bus.lose         = loseReg;
    assign bus.time_left    = timeLeftReg;
    assign bus.lives        = livesReg;
    assign bus.scrolls_left = scrollsLeftReg;
    assign bus.state        = stateReg;

endmodule
